apb_cmd_requester: RTL
======================

Name: apb_cmd_requester

Overview:
- Executes one APB transaction per command issued by the instruction decode stage.
- Command fields are the decoded device index, register address and write data, plus a read/write flag from the control unit.
- Drives the shared APB bus with a per-device one-hot PSEL, muxes the addressed device's PREADY/PRDATA/PSLVERR back, and returns a one-cycle response carrying read data and error status to the core.

Parameters:
NUM_DEV, 4, number of APB completers; legal range 1..16. The device index is 4 bits; an index >= NUM_DEV is illegal.
TIMEOUT, 16, maximum ACCESS cycles waiting for PREADY before abort; legal range 2..255.

Ports:
pclk  in  1  bus and core clock; all state updates on the rising edge
presetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_write  in  1  1 = write, 0 = read
cmd_device  in  4  target device index
cmd_addr  in  8  APB register address
cmd_wdata  in  8  write data
psel  out  NUM_DEV  one-hot completer select
penable  out  1  APB access phase
pwrite  out  1  APB direction
paddr  out  8  APB address
pwdata  out  8  APB write data
prdata  in  8*NUM_DEV  per-device read data; device k occupies bits [8k+7:8k]
pready  in  NUM_DEV  per-device ready
pslverr  in  NUM_DEV  per-device error
rsp_valid  out  1  one-cycle response strobe
rsp_rdata  out  8  read data; 0 for writes and for errors
rsp_err  out  1  completer error, illegal device, or timeout
rsp_timeout  out  1  error cause was timeout
busy  out  1  high in every state except IDLE

Behaviour:
- All outputs are registered.
- Reset values: state = IDLE, cmd_ready = 1, psel = 0, penable = 0, pwrite = 0, paddr = 0, pwdata = 0, rsp_* = 0, busy = 0, wait counter = 0.
- Reset is asynchronous; asserting it mid-transaction drops psel/penable immediately and no response is produced.

State machine: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready = 1. A command is accepted when cmd_valid && cmd_ready; all fields are latched on that edge.
  - cmd_device < NUM_DEV: go to SETUP.
  - Otherwise go to RESP with rsp_err = 1. No bus activity occurs.
- SETUP (1 cycle): psel[dev] = 1, penable = 0; paddr/pwdata/pwrite are driven from the latched values. Always go to ACCESS.
- ACCESS: psel[dev] = 1, penable = 1. Only the selected device's pready, pslverr and prdata slice are observed; other devices' signals are ignored.
  - pready[dev] = 1:
    - Read: capture prdata slice into rsp_rdata.
    - rsp_err = pslverr[dev].
    - A read with pslverr forces rsp_rdata = 0.
    - Drop psel/penable on the next edge and go to RESP.
  - pready[dev] = 0: increment the wait counter. When the counter reaches TIMEOUT-1 without pready, go to RESP with rsp_err = 1 and rsp_timeout = 1; psel/penable are dropped.
  - pready arriving on the same cycle the counter hits TIMEOUT-1 counts as completion, not timeout.
- RESP (1 cycle): rsp_valid = 1 with rsp_rdata/rsp_err/rsp_timeout; cmd_ready = 0. Go to IDLE.
  - rsp_* fields hold their values until the next RESP.
  - The wait counter clears on entry to SETUP.
- Latency with zero wait states: accept at edge N, SETUP in cycle N+1, ACCESS in N+2, RESP (rsp_valid) in N+3, cmd_ready = 1 again in N+4.
  - Each wait state adds 1 cycle.
  - Illegal-device commands respond at N+1.
- cmd_ready is low from the accept edge through RESP. Commands presented while cmd_ready = 0 are not accepted, and the source must hold them.
- PSEL is never asserted for more than one device, and penable is never high without psel.
- paddr/pwdata/pwrite are stable from SETUP through the end of ACCESS. After a transfer they retain their last values; only psel/penable return to 0.

Test Plan:
- Write with zero wait states: cmd write, dev = 2, addr = 0x10, wdata = 0xA5 -> psel = 0b0100 in SETUP; penable in the next cycle; rsp_valid 3 cycles after accept with rsp_err = 0 and rsp_rdata = 0.
- Read with 3 wait states: dev = 1, addr = 0x04; the device returns prdata = 0x5C after 3 low-pready cycles -> rsp_valid 6 cycles after accept, rsp_rdata = 0x5C. Other devices driving garbage on prdata/pready have no effect.
- Completer error: read of dev = 0 with pslverr = 1 on the pready cycle -> rsp_err = 1, rsp_timeout = 0, rsp_rdata = 0.
- Illegal device: dev = 7 with NUM_DEV = 4 -> psel stays 0, rsp_valid 1 cycle after accept, rsp_err = 1.
- Timeout: pready held low -> exactly TIMEOUT (16) ACCESS cycles, then rsp_err = 1 and rsp_timeout = 1; psel and penable drop. A follow-up command is accepted normally.
- Reset mid-ACCESS: presetn low during the 2nd wait cycle -> psel/penable go to 0 asynchronously and no rsp_valid is produced. After release, cmd_ready = 1 and a new read completes correctly; back-to-back commands with cmd_valid held high are accepted only in IDLE.

Source files
------------

// File: rtl/apb_cmd_requester.sv
// APB requester: turns one decoded core command into one APB transfer and
// returns a single-cycle response with read data and error status.
module apb_cmd_requester #(
  parameter int NUM_DEV = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                 pclk,
  input  logic                 presetn,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [3:0]           cmd_device,
  input  logic [7:0]           cmd_addr,
  input  logic [7:0]           cmd_wdata,
  output logic [NUM_DEV-1:0]   psel,
  output logic                 penable,
  output logic                 pwrite,
  output logic [7:0]           paddr,
  output logic [7:0]           pwdata,
  input  logic [8*NUM_DEV-1:0] prdata,
  input  logic [NUM_DEV-1:0]   pready,
  input  logic [NUM_DEV-1:0]   pslverr,
  output logic                 rsp_valid,
  output logic [7:0]           rsp_rdata,
  output logic                 rsp_err,
  output logic                 rsp_timeout,
  output logic                 busy
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t             r_state;
  logic [7:0]         r_wait_cnt;

  logic [NUM_DEV-1:0] w_dev_onehot;
  logic               w_dev_legal;
  logic               w_sel_ready;
  logic               w_sel_err;
  logic [7:0]         w_sel_rdata;
  logic [7:0]         w_rdata_slice [NUM_DEV];

  assign w_dev_legal = ({1'b0, cmd_device} < 5'(NUM_DEV));

  // psel itself is the device mask, so unselected completers never leak in.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DEV; gi++) begin : g_dev
      assign w_dev_onehot[gi]  = (cmd_device == 4'(gi));
      assign w_rdata_slice[gi] = prdata[8*gi +: 8] & {8{psel[gi]}};
    end
  endgenerate

  assign w_sel_ready = |(pready & psel);
  assign w_sel_err   = |(pslverr & psel);

  always_comb begin
    w_sel_rdata = '0;
    for (int k = 0; k < NUM_DEV; k++) begin
      w_sel_rdata = w_sel_rdata | w_rdata_slice[k];
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= '0;
      cmd_ready   <= 1'b1;
      psel        <= '0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (w_dev_legal) begin
              psel       <= w_dev_onehot;
              pwrite     <= cmd_write;
              paddr      <= cmd_addr;
              pwdata     <= cmd_wdata;
              r_wait_cnt <= '0;
              r_state    <= S_SETUP;
            end else begin
              rsp_valid   <= 1'b1;
              rsp_err     <= 1'b1;
              rsp_timeout <= 1'b0;
              rsp_rdata   <= '0;
              r_state     <= S_RESP;
            end
          end
        end
        S_SETUP: begin
          penable <= 1'b1;
          r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          // Ready on the final wait cycle still counts as a normal completion.
          if (w_sel_ready) begin
            psel        <= '0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_err     <= w_sel_err;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= (pwrite || w_sel_err) ? 8'h00 : w_sel_rdata;
            r_state     <= S_RESP;
          end else if (r_wait_cnt == 8'(TIMEOUT - 1)) begin
            psel        <= '0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= '0;
            r_state     <= S_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        S_RESP: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
